// File: rtl/car_pkg.sv
`default_nettype none
// ============================================================================
// Module      : car_pkg
// Description : Shared widths, SPI master state encoding and default divider
//               for the car_dig stimulus environment.
// Revision    : 1.0 - initial release
// ============================================================================
package car_pkg;

    localparam int CMD_W        = 16;   // SPI command/response word width
    localparam int SAR_W        = 12;   // SAR code / analog value width
    localparam int SCLK_DIV_DEF = 32;   // clk cycles per SCLK period

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/car_stim_env_if.sv
`default_nettype none
// ============================================================================
// Module      : car_stim_env_if
// Description : Four-wire SPI bus between the stimulus master and the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
interface car_stim_env_if;

    logic SCLK;
    logic SS_n;
    logic MOSI;
    logic MISO;

    modport master (output SCLK, output SS_n, output MOSI, input MISO);
    modport slave  (input SCLK, input SS_n, input MOSI, output MISO);

endinterface
`default_nettype wire

// File: rtl/spi_mstr_core.sv
`default_nettype none
// ============================================================================
// Module      : spi_mstr_core
// Description : 16-bit SPI mode-0 master. One command per wrt_cmd, MSB first,
//               response captured on SCLK rises and presented with done.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mstr_core
    import car_pkg::*;
#(
    parameter int SCLK_DIV = SCLK_DIV_DEF
)(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             wrt_cmd,
    input  wire logic [CMD_W-1:0] command,
    output logic                  done,
    output logic [CMD_W-1:0]      resp,
    car_stim_env_if.master        spi
);

    localparam int CNT_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(CMD_W);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(SCLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(SCLK_DIV / 2);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CMD_W - 1);

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CMD_W-1:0]  tx_q, tx_d;
    logic [CMD_W-1:0]  rx_q, rx_d;
    logic [CMD_W-1:0]  resp_q, resp_d;
    logic              sclk_q, sclk_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;

    // Next-state logic: divider count, SCLK edges and shift-register moves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        resp_d  = resp_q;
        sclk_d  = sclk_q;
        ss_n_d  = ss_n_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wrt_cmd) begin
                    tx_d    = command;
                    mosi_d  = command[CMD_W-1];
                    ss_n_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = FRONT;
                end
            end
            FRONT: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                // Rising SCLK: MISO is sampled on the same clk edge SCLK goes high.
                if (cnt_q == HALF_M1) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[CMD_W-2:0], spi.MISO};
                end
                // Falling SCLK: present the next command bit.
                if (cnt_q == FULL_M1) begin
                    sclk_d = 1'b0;
                    cnt_d  = '0;
                    tx_d   = {tx_q[CMD_W-2:0], 1'b0};
                    mosi_d = tx_q[CMD_W-2];
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = BACK;
                    end
                end
            end
            BACK: begin
                if (cnt_q == HALF) begin
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                    resp_d  = rx_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus outputs; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            resp_q  <= '0;
            sclk_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            resp_q  <= resp_d;
            sclk_q  <= sclk_d;
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign done     = done_q;
    assign resp     = resp_q;
    assign spi.SCLK = sclk_q;
    assign spi.SS_n = ss_n_q;
    assign spi.MOSI = mosi_q;

endmodule
`default_nettype wire

// File: rtl/car_stim_env.sv
`default_nettype none
// ============================================================================
// Module      : car_stim_env
// Description : Stimulus environment for car_dig: SPI master, SAR comparator
//               model and smpl-driven analog value sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module car_stim_env
    import car_pkg::*;
#(
    parameter int SCLK_DIV  = SCLK_DIV_DEF,
    parameter int SEQ_DEPTH = 256,
    // Table image, entry i at bits [i*24 +: 24] as {cos[11:0], sin[11:0]}.
    parameter logic [SEQ_DEPTH*2*SAR_W-1:0] SEQ_INIT = '0
)(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             wrt_cmd,
    input  wire logic [CMD_W-1:0] command,
    output logic                  done,
    output logic [CMD_W-1:0]      resp,
    car_stim_env_if.master        spi,
    input  wire logic [SAR_W-1:0] cosSAR,
    input  wire logic [SAR_W-1:0] sinSAR,
    input  wire logic             smpl,
    output logic [SAR_W-1:0]      ana_cos,
    output logic [SAR_W-1:0]      ana_sin,
    output logic                  gt_cos,
    output logic                  gt_sin
);

    localparam int IDX_W = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_DEPTH - 1);

    spi_mstr_core #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt_cmd (wrt_cmd),
        .command (command),
        .done    (done),
        .resp    (resp),
        .spi     (spi)
    );

    logic [2*SAR_W-1:0] seq_table [SEQ_DEPTH];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [2*SAR_W-1:0] entry;

    for (genvar i = 0; i < SEQ_DEPTH; i++) begin : g_tbl
        assign seq_table[i] = SEQ_INIT[i*2*SAR_W +: 2*SAR_W];
    end

    // Next table index, wrapping after the last entry.
    always_comb begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Index advances on every smpl rise, independent of clk.
    always_ff @(posedge smpl or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Current analog sample pair.
    always_comb begin
        entry = seq_table[idx_q];
    end

    assign ana_cos = entry[2*SAR_W-1:SAR_W];
    assign ana_sin = entry[SAR_W-1:0];

    // Comparator model: strictly greater, equality reads as 0.
    assign gt_cos = (ana_cos > cosSAR);
    assign gt_sin = (ana_sin > sinSAR);

endmodule
`default_nettype wire

// File: tb/tb_car_stim_env.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_stim_env
// Description : Self-checking bench for car_stim_env with an SPI slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_stim_env;
    import car_pkg::*;

    localparam int DIV = 32;
    localparam int LAT = 1 + 17 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt_cmd = 1'b0;
    logic [15:0] command = '0;
    logic        done;
    logic [15:0] resp;
    logic [11:0] cosSAR = '0;
    logic [11:0] sinSAR = '0;
    logic        smpl = 1'b0;
    logic [11:0] ana_cos, ana_sin;
    logic        gt_cos, gt_sin;

    int checks = 0;
    int failures = 0;

    // Reference sequencer table and index
    logic [11:0] tbl_cos [2] = '{12'h800, 12'hFFF};
    logic [11:0] tbl_sin [2] = '{12'h000, 12'h123};
    int exp_idx = 0;

    car_stim_env_if bus ();

    car_stim_env #(
        .SCLK_DIV  (DIV),
        .SEQ_DEPTH (2),
        .SEQ_INIT  ({24'hFFF123, 24'h800000})
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt_cmd (wrt_cmd),
        .command (command),
        .done    (done),
        .resp    (resp),
        .spi     (bus),
        .cosSAR  (cosSAR),
        .sinSAR  (sinSAR),
        .smpl    (smpl),
        .ana_cos (ana_cos),
        .ana_sin (ana_sin),
        .gt_cos  (gt_cos),
        .gt_sin  (gt_sin)
    );

    always #5 clk = ~clk;

    // SPI slave: sends slave_word MSB first, changing on SCLK falls; records MOSI on rises.
    logic [15:0] slave_word = '0;
    logic [15:0] rx_word = '0;
    int          rises = 0;
    int          falls = 0;
    logic        sclk_prev = 1'b0;
    logic        ss_prev = 1'b1;
    logic        miso_drv = 1'b0;
    assign bus.MISO = miso_drv;

    always @(posedge clk) begin
        #2;
        if (ss_prev && !bus.SS_n) begin
            rises = 0;
            falls = 0;
        end
        if (!bus.SS_n) begin
            if (!sclk_prev && bus.SCLK) begin
                rx_word = {rx_word[14:0], bus.MOSI};
                rises++;
            end
            if (sclk_prev && !bus.SCLK) falls++;
        end
        miso_drv  = (falls < 16) ? slave_word[15 - falls] : 1'b0;
        sclk_prev = bus.SCLK;
        ss_prev   = bus.SS_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_smpl();
        smpl = 1'b1;
        #2;
        smpl = 1'b0;
        #2;
        exp_idx = (exp_idx + 1) % 2;
    endtask

    // One full transaction, called at a negedge with wrt_cmd low.
    task automatic run_txn(input logic [15:0] cmd, input logic [15:0] word, input string tag);
        int   lat;
        int   ndone;
        logic ss_early;
        lat      = -1;
        ndone    = 0;
        ss_early = 1'b1;
        slave_word = word;
        command    = cmd;
        wrt_cmd    = 1'b1;
        @(negedge clk);
        wrt_cmd = 1'b0;
        for (int k = 1; k <= LAT + 20; k++) begin
            @(negedge clk);
            if (k == 1) ss_early = bus.SS_n;
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = k;
                chk({tag, "_resp"}, resp, word);
                chk({tag, "_mosi"}, rx_word, cmd);
                chk({tag, "_rises"}, rises, 16);
                chk({tag, "_ssn_done"}, bus.SS_n, 1'b1);
            end
        end
        chk({tag, "_ssn_low"}, ss_early, 1'b0);
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_resp_hold"}, resp, word);
    endtask

    initial begin
        logic [15:0] c, w;
        int   ndone, first, second;
        logic ss_after;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ssn", bus.SS_n, 1'b1);
        chk("rst_sclk", bus.SCLK, 1'b0);
        chk("rst_mosi", bus.MOSI, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_resp", resp, 16'h0);
        chk("rst_ana_cos", ana_cos, 12'h800);
        chk("rst_ana_sin", ana_sin, 12'h000);
        rst_n = 1'b1;
        @(negedge clk);

        // Comparator boundaries, cos channel at entry 0
        cosSAR = 12'h7FF; #1; chk("gt_cos_7ff", gt_cos, 1'b1);
        cosSAR = 12'h800; #1; chk("gt_cos_800", gt_cos, 1'b0);
        cosSAR = 12'h801; #1; chk("gt_cos_801", gt_cos, 1'b0);

        // Sequencer step to entry 1, sin channel boundaries
        pulse_smpl();
        chk("seq1_cos", ana_cos, 12'hFFF);
        chk("seq1_sin", ana_sin, 12'h123);
        sinSAR = 12'h122; #1; chk("gt_sin_122", gt_sin, 1'b1);
        sinSAR = 12'h123; #1; chk("gt_sin_123", gt_sin, 1'b0);
        sinSAR = 12'h124; #1; chk("gt_sin_124", gt_sin, 1'b0);
        cosSAR = 12'hFFF; #1; chk("gt_cos_fff", gt_cos, 1'b0);

        // Wrap back to entry 0
        pulse_smpl();
        chk("seq_wrap_cos", ana_cos, 12'h800);
        chk("seq_wrap_sin", ana_sin, 12'h000);

        // Random smpl steps and SAR codes against the reference table
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(1, 0) == 1) pulse_smpl();
            cosSAR = 12'($urandom);
            sinSAR = 12'($urandom);
            #1;
            chk("rnd_ana_cos", ana_cos, tbl_cos[exp_idx]);
            chk("rnd_ana_sin", ana_sin, tbl_sin[exp_idx]);
            chk("rnd_gt_cos", gt_cos, tbl_cos[exp_idx] > cosSAR);
            chk("rnd_gt_sin", gt_sin, tbl_sin[exp_idx] > sinSAR);
        end

        // Directed SPI transaction
        @(negedge clk);
        run_txn(16'hA5C3, 16'h1234, "txn_a5c3");

        // Random SPI transactions
        for (int i = 0; i < 3; i++) begin
            run_txn(16'($urandom), 16'($urandom), "txn_rnd");
        end

        // wrt_cmd held high for 600 clks
        c = 16'($urandom);
        w = 16'($urandom) | 16'h8000;
        slave_word = w;
        command    = c;
        wrt_cmd    = 1'b1;
        ndone      = 0;
        first      = -1;
        ss_after   = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = k;
                chk("hold_resp", resp, w);
            end
            if (k == LAT + 1) ss_after = bus.SS_n;
        end
        wrt_cmd = 1'b0;
        chk("hold_ndone", ndone, 1);
        chk("hold_first", first, LAT);
        chk("hold_restart_ssn", ss_after, 1'b0);
        second = -1;
        for (int k = 600; k < 2 * LAT + 60; k++) begin
            @(negedge clk);
            if (done === 1'b1 && second < 0) begin
                second = k;
                chk("hold2_resp", resp, w);
                chk("hold2_mosi", rx_word, c);
            end
        end
        chk("hold2_latency", second, 2 * LAT + 1);

        // Abort with rst_n at the 8th SCLK rise
        if (exp_idx == 0) pulse_smpl();
        slave_word = 16'($urandom);
        command    = 16'($urandom);
        wrt_cmd    = 1'b1;
        @(negedge clk);
        wrt_cmd = 1'b0;
        for (int k = 0; k < 1000 && rises < 8; k++) @(negedge clk);
        chk("abort_reach_rise8", rises, 8);
        rst_n = 1'b0;
        exp_idx = 0;
        #1;
        chk("abort_ssn", bus.SS_n, 1'b1);
        chk("abort_sclk", bus.SCLK, 1'b0);
        chk("abort_resp", resp, 16'h0);
        chk("abort_done", done, 1'b0);
        chk("abort_seq_cos", ana_cos, 12'h800);
        chk("abort_seq_sin", ana_sin, 12'h000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_resp_kept", resp, 16'h0);
        run_txn(16'h0001, 16'($urandom), "txn_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
